// File: rtl/redmule_tcdm_lane_sched_pkg.sv
// Shared TCDM lane types and helpers for the RedMulE lane scheduler.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: TCDM_LANE_W, lane_req_t {add, wen, be, data}, lane_addr().
package redmule_tcdm_lane_sched_pkg;

  localparam int unsigned TCDM_LANE_W = 32;
  localparam int unsigned TCDM_BE_W   = TCDM_LANE_W / 8;

  typedef struct packed {
    logic [TCDM_LANE_W-1:0] add;
    logic                   wen;
    logic [TCDM_BE_W-1:0]   be;
    logic [TCDM_LANE_W-1:0] data;
  } lane_req_t;

  // Word address of lane idx; the 32-bit sum wraps naturally past 0xFFFF_FFFC.
  function automatic logic [TCDM_LANE_W-1:0] lane_addr(input logic [TCDM_LANE_W-1:0] base,
                                                       input int unsigned idx);
    logic [TCDM_LANE_W-1:0] ofs;
    ofs = {idx[TCDM_LANE_W-3:0], 2'b00};
    return base + ofs;
  endfunction

endpackage

// File: rtl/redmule_lane_rsp_fifo.sv
// Per-lane read-response FIFO, DEPTH entries of DW bits.
// Latency: one cycle from push to head visible; head read combinationally.
// Backpressure: none; push when full is dropped unless a pop frees a slot the same cycle.
// Ports: clk_i, rst_i (sync, active-high), push_i/data_i, pop_i, data_o (head), full_o, empty_o, count_o.
module redmule_lane_rsp_fifo #(
  parameter  int unsigned DW    = 32,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int k = 0; k < int'(DEPTH); k++) mem_q[k] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/redmule_tcdm_lane_sched.sv
// Splits one wide TCDM request over MP 32-bit lanes and reassembles skewed lane read responses.
// Latency: w_gnt_o combinational once every lane has granted; w_r_valid_o one cycle after the last lane response.
// Backpressure: reads stall (no lane req) at MAX_OUTST outstanding; responses cannot be stalled upstream.
// Ports: clk_i, rst_i; wide side w_req_i/w_gnt_o/w_add_i/w_wen_i/w_be_i/w_data_i/w_r_valid_o/w_r_data_o;
//        lane side l_req_o/l_gnt_i/l_add_o/l_wen_o/l_be_o/l_data_o/l_r_valid_i/l_r_data_i; busy_o, err_o (sticky).
module redmule_tcdm_lane_sched
  import redmule_tcdm_lane_sched_pkg::*;
#(
  parameter int unsigned MP        = 4,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        w_req_i,
  output logic                        w_gnt_o,
  input  logic [TCDM_LANE_W-1:0]      w_add_i,
  input  logic                        w_wen_i,
  input  logic [TCDM_BE_W*MP-1:0]     w_be_i,
  input  logic [TCDM_LANE_W*MP-1:0]   w_data_i,
  output logic                        w_r_valid_o,
  output logic [TCDM_LANE_W*MP-1:0]   w_r_data_o,
  output logic [MP-1:0]               l_req_o,
  input  logic [MP-1:0]               l_gnt_i,
  output logic [MP*TCDM_LANE_W-1:0]   l_add_o,
  output logic [MP-1:0]               l_wen_o,
  output logic [MP*TCDM_BE_W-1:0]     l_be_o,
  output logic [MP*TCDM_LANE_W-1:0]   l_data_o,
  input  logic [MP-1:0]               l_r_valid_i,
  input  logic [MP*TCDM_LANE_W-1:0]   l_r_data_i,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam int unsigned OW = $clog2(MAX_OUTST + 1);

  logic [MP-1:0]          done_q, done_d;
  logic [OW-1:0]          outst_q, outst_d;
  logic                   err_q, err_d;
  logic                   stall, issue_ok, rd_inc, rd_dec;
  logic [MP-1:0]          fifo_push, fifo_full, fifo_empty, unsol;
  logic [OW-1:0]          fifo_cnt [MP];
  logic [TCDM_LANE_W-1:0] fifo_dat [MP];
  lane_req_t              lane_req [MP];

  // Handshake outputs are forced low while reset is asserted.
  assign stall       = w_wen_i & (outst_q == OW'(MAX_OUTST));
  assign issue_ok    = w_req_i & ~stall & ~rst_i;
  assign l_req_o     = {MP{issue_ok}} & ~done_q;
  assign w_gnt_o     = issue_ok & (&(done_q | l_gnt_i));
  assign w_r_valid_o = ~rst_i & (&(~fifo_empty));
  assign busy_o      = ~rst_i & (w_req_i | (outst_q != '0));
  assign err_o       = err_q;

  assign rd_inc = w_gnt_o & w_wen_i;
  assign rd_dec = w_r_valid_o;

  for (genvar i = 0; i < MP; i++) begin : g_lane
    assign lane_req[i].add  = lane_addr(w_add_i, i);
    assign lane_req[i].wen  = w_wen_i;
    assign lane_req[i].be   = w_be_i[TCDM_BE_W*i +: TCDM_BE_W];
    assign lane_req[i].data = w_data_i[TCDM_LANE_W*i +: TCDM_LANE_W];

    assign l_add_o[TCDM_LANE_W*i +: TCDM_LANE_W]  = lane_req[i].add;
    assign l_wen_o[i]                             = lane_req[i].wen;
    assign l_be_o[TCDM_BE_W*i +: TCDM_BE_W]       = lane_req[i].be;
    assign l_data_o[TCDM_LANE_W*i +: TCDM_LANE_W] = lane_req[i].data;

    // A lane already holding as many entries as reads are outstanding has
    // nothing left to answer: the response is unsolicited and dropped.
    assign unsol[i]     = fifo_full[i] | (fifo_cnt[i] >= outst_q);
    assign fifo_push[i] = l_r_valid_i[i] & ~unsol[i];

    redmule_lane_rsp_fifo #(
      .DW    (TCDM_LANE_W),
      .DEPTH (MAX_OUTST)
    ) u_rsp_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push[i]),
      .data_i  (l_r_data_i[TCDM_LANE_W*i +: TCDM_LANE_W]),
      .pop_i   (rd_dec),
      .data_o  (fifo_dat[i]),
      .full_o  (fifo_full[i]),
      .empty_o (fifo_empty[i]),
      .count_o (fifo_cnt[i])
    );

    assign w_r_data_o[TCDM_LANE_W*i +: TCDM_LANE_W] = fifo_dat[i];
  end

  always_comb begin
    done_d  = done_q | (l_req_o & l_gnt_i);
    if (w_gnt_o) done_d = '0;
    outst_d = outst_q;
    if (rd_inc && !rd_dec)      outst_d = outst_q + OW'(1);
    else if (rd_dec && !rd_inc) outst_d = outst_q - OW'(1);
    err_d   = err_q | (|(l_r_valid_i & unsol));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_q  <= '0;
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      done_q  <= done_d;
      outst_q <= outst_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_redmule_tcdm_lane_sched.sv
// Directed bench for redmule_tcdm_lane_sched (MP=4, MAX_OUTST=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Ports: drives every DUT input, observes every DUT output plus the outstanding counter.
module tb_redmule_tcdm_lane_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         w_req, w_wen;
  logic [31:0]  w_add;
  logic [15:0]  w_be;
  logic [127:0] w_data;
  logic         w_gnt, w_r_valid;
  logic [127:0] w_r_data;
  logic [3:0]   l_req, l_gnt, l_wen, l_r_valid;
  logic [127:0] l_add, l_data, l_r_data;
  logic [15:0]  l_be;
  logic         busy, err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  redmule_tcdm_lane_sched #(.MP(4), .MAX_OUTST(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .w_req_i     (w_req),
    .w_gnt_o     (w_gnt),
    .w_add_i     (w_add),
    .w_wen_i     (w_wen),
    .w_be_i      (w_be),
    .w_data_i    (w_data),
    .w_r_valid_o (w_r_valid),
    .w_r_data_o  (w_r_data),
    .l_req_o     (l_req),
    .l_gnt_i     (l_gnt),
    .l_add_o     (l_add),
    .l_wen_o     (l_wen),
    .l_be_o      (l_be),
    .l_data_o    (l_data),
    .l_r_valid_i (l_r_valid),
    .l_r_data_i  (l_r_data),
    .busy_o      (busy),
    .err_o       (err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; w_req = 1'b0; w_wen = 1'b0; w_add = '0; w_be = '0; w_data = '0;
    l_gnt = '0; l_r_valid = '0; l_r_data = '0;
    tick(); tick();
    chk("rst_gnt", w_gnt, 0);
    chk("rst_req", l_req, 0);
    chk("rst_rvalid", w_r_valid, 0);
    chk("rst_rdata", w_r_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();

    // Read at 0x100, all lanes grant together.
    w_req = 1; w_wen = 1; w_add = 32'h100; w_be = 16'hFFFF; l_gnt = 4'hF;
    settle();
    chk("t1_gnt", w_gnt, 1);
    chk("t1_req", l_req, 4'hF);
    chk("t1_add", l_add, 128'h0000010C_00000108_00000104_00000100);
    chk("t1_wen", l_wen, 4'hF);
    chk("t1_be", l_be, 16'hFFFF);
    chk("t1_busy", busy, 1);
    tick();
    w_req = 0; l_gnt = 0;
    settle();
    chk("t1_outst", dut.outst_q, 1);

    // Skewed responses for read 0x100: lane 0 first, lanes 1-3 three cycles later.
    l_r_valid = 4'b0001; l_r_data = 128'h000000A0;
    tick();
    l_r_valid = 0;
    settle();
    chk("t3_early", w_r_valid, 0);
    tick(); tick();
    l_r_valid = 4'b1110; l_r_data = 128'h000000A3_000000A2_000000A1_00000000;
    settle();
    chk("t3_pre", w_r_valid, 0);
    tick();
    l_r_valid = 0;
    settle();
    chk("t3_valid", w_r_valid, 1);
    chk("t3_data", w_r_data, 128'h000000A3_000000A2_000000A1_000000A0);
    tick();
    chk("t3_once", w_r_valid, 0);
    chk("t3_outst", dut.outst_q, 0);
    chk("t3_busy", busy, 0);

    // Read at 0x200 with grants skewed: lane 3 first, lane 0 last.
    w_req = 1; w_wen = 1; w_add = 32'h200; l_gnt = 4'b1000;
    settle();
    chk("t2_c0_req", l_req, 4'b1111);
    chk("t2_c0_gnt", w_gnt, 0);
    tick();
    l_gnt = 4'b0100;
    settle();
    chk("t2_c1_req", l_req, 4'b0111);
    chk("t2_c1_gnt", w_gnt, 0);
    tick();
    l_gnt = 4'b0010;
    settle();
    chk("t2_c2_req", l_req, 4'b0011);
    chk("t2_c2_gnt", w_gnt, 0);
    tick();
    l_gnt = 4'b0001;
    settle();
    chk("t2_c3_req", l_req, 4'b0001);
    chk("t2_c3_gnt", w_gnt, 1);
    tick();

    // Second outstanding read at 0x300, then a third read must stall.
    w_add = 32'h300; l_gnt = 4'hF;
    settle();
    chk("t4_rd2_gnt", w_gnt, 1);
    tick();
    w_add = 32'h500;
    settle();
    chk("t4_outst_max", dut.outst_q, 2);
    chk("t4_stall_req", l_req, 0);
    chk("t4_stall_gnt", w_gnt, 0);
    tick();
    chk("t4_stall_req2", l_req, 0);
    // A write is still issued while reads are stalled; its address wraps.
    w_wen = 0; w_add = 32'hFFFF_FFF8; w_be = 16'h0F3C;
    w_data = 128'h44444444_33333333_22222222_11111111;
    settle();
    chk("t4_wr_req", l_req, 4'hF);
    chk("t4_wr_gnt", w_gnt, 1);
    chk("t4_wr_wen", l_wen, 0);
    chk("t4_wr_add", l_add, 128'h00000004_00000000_FFFFFFFC_FFFFFFF8);
    chk("t4_wr_be", l_be, 16'h0F3C);
    chk("t4_wr_data", l_data, 128'h44444444_33333333_22222222_11111111);
    tick();
    w_wen = 1; w_add = 32'h500; l_gnt = 0;
    settle();
    chk("t4_wr_outst", dut.outst_q, 2);
    // Responses for read 0x200 arrive together.
    l_r_valid = 4'hF; l_r_data = 128'h000000B3_000000B2_000000B1_000000B0;
    tick();
    l_r_valid = 0;
    settle();
    chk("t4_pop_valid", w_r_valid, 1);
    chk("t4_pop_data", w_r_data, 128'h000000B3_000000B2_000000B1_000000B0);
    chk("t4_pop_req", l_req, 0);
    tick();
    // Read 0x500 issues while read 0x300's responses trickle in.
    l_gnt = 4'b0111; l_r_valid = 4'b0111; l_r_data = 128'h00000000_000000C2_000000C1_000000C0;
    settle();
    chk("t5_a_req", l_req, 4'hF);
    chk("t5_a_gnt", w_gnt, 0);
    tick();
    l_gnt = 0; l_r_valid = 4'b1000; l_r_data = 128'h000000C3_00000000_00000000_00000000;
    settle();
    chk("t5_b_req", l_req, 4'b1000);
    chk("t5_b_rvalid", w_r_valid, 0);
    tick();
    // Last grant of 0x500 coincides with the wide response of 0x300.
    l_r_valid = 0; l_gnt = 4'b1000;
    settle();
    chk("t5_c_gnt", w_gnt, 1);
    chk("t5_c_rvalid", w_r_valid, 1);
    chk("t5_c_data", w_r_data, 128'h000000C3_000000C2_000000C1_000000C0);
    tick();
    w_req = 0; l_gnt = 0;
    settle();
    chk("t5_outst", dut.outst_q, 1);
    chk("t5_rvalid_off", w_r_valid, 0);
    l_r_valid = 4'hF; l_r_data = 128'h000000D3_000000D2_000000D1_000000D0;
    tick();
    l_r_valid = 0;
    settle();
    chk("t5_d_data", w_r_data, 128'h000000D3_000000D2_000000D1_000000D0);
    chk("t5_d_valid", w_r_valid, 1);
    tick();
    chk("t5_final_outst", dut.outst_q, 0);

    // Unsolicited lane response sets the sticky error and is dropped.
    l_r_valid = 4'b0100; l_r_data = 128'h00000000_000000EE_00000000_00000000;
    settle();
    chk("t6_err_pre", err, 0);
    tick();
    l_r_valid = 0;
    settle();
    chk("t6_err_set", err, 1);
    chk("t6_dropped", w_r_valid, 0);
    tick(); tick();
    chk("t6_err_sticky", err, 1);

    // Reset in the middle of a partially granted read.
    w_req = 1; w_wen = 1; w_add = 32'h600; l_gnt = 4'b0011;
    tick();
    l_gnt = 0; rst = 1;
    settle();
    chk("t6_rst_req", l_req, 0);
    chk("t6_rst_gnt", w_gnt, 0);
    chk("t6_rst_busy", busy, 0);
    tick();
    chk("t6_rst_err", err, 0);
    chk("t6_rst_rvalid", w_r_valid, 0);
    rst = 0;
    settle();
    chk("t6_done_clr", l_req, 4'hF);
    l_gnt = 4'hF;
    settle();
    chk("t6_post_gnt", w_gnt, 1);
    tick();
    w_req = 0; l_gnt = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
